// File: rtl/song_sequencer.sv
// song_sequencer: melody ROM autoplay with live-key override to the buzzer.
// Ports: clk, rst_n (sync, active-low), play/stop pulses, loop_en level,
// key_note live key, rom_addr/rom_data melody ROM (1-cycle read latency),
// note_out registered buzzer note, busy, done (end-of-song pulse).
// Optional: define SONG_SEQ_GAP_EN for GAP_CYCLES of silence after each note.
module song_sequencer #(
  parameter int TICK_DIV   = 100_000,
  parameter int SONG_LEN   = 32,
  parameter int GAP_CYCLES = 5_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        play,
  input  logic                        stop,
  input  logic                        loop_en,
  input  logic [7:0]                  key_note,
  output logic [$clog2(SONG_LEN)-1:0] rom_addr,
  input  logic [13:0]                 rom_data,
  output logic [7:0]                  note_out,
  output logic                        busy,
  output logic                        done
);

  localparam int AW = $clog2(SONG_LEN);
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (TICK_DIV < 2) begin : g_bad_tick
    $error("TICK_DIV must be >= 2");
  end
  if (SONG_LEN < 2) begin : g_bad_len
    $error("SONG_LEN must be >= 2");
  end
  if (GAP_CYCLES < 1 || GW < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1");
  end

`ifdef SONG_SEQ_GAP_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, PLAY, GAP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, PLAY
  } state_t;
`endif

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [7:0]      cur_note;
  logic [5:0]      dur_cnt;
  logic [TW-1:0]   tick_cnt;
`ifdef SONG_SEQ_GAP_EN
  logic [GW-1:0]   gap_cnt;
`endif

  logic [7:0] seq_note;
  logic       tick_wrap;
  logic       note_end;
  logic       adv;
  logic       eos;

  assign rom_addr  = ptr;
  assign seq_note  = (state == PLAY) ? cur_note : 8'd0;
  assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
  assign note_end  = tick_wrap && (dur_cnt == 6'd1);

  // adv: current entry finished; eos: song over (marker or last entry)
  always_comb begin
    adv = 1'b0;
    eos = 1'b0;
    case (state)
      LOAD: eos = (rom_data[5:0] == 6'd0);
`ifdef SONG_SEQ_GAP_EN
      GAP:  adv = (gap_cnt == GW'(GAP_CYCLES - 1));
`else
      PLAY: adv = note_end;
`endif
      default: ;
    endcase
    if (adv && ptr == AW'(SONG_LEN - 1))
      eos = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cur_note <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
`ifdef SONG_SEQ_GAP_EN
      gap_cnt  <= '0;
`endif
      note_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      note_out <= (key_note != 8'd0) ? key_note : seq_note;
      if (stop) begin
        // abort silences the sequencer on the same edge
        state    <= IDLE;
        ptr      <= '0;
        busy     <= 1'b0;
        note_out <= key_note;
      end else if (eos) begin
        ptr <= '0;
        if (loop_en) begin
          state <= FETCH;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (adv) begin
        ptr   <= ptr + AW'(1);
        state <= FETCH;
      end else begin
        unique case (state)
          IDLE: begin
            ptr <= '0;
            if (play) begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            cur_note <= rom_data[13:6];
            dur_cnt  <= rom_data[5:0];
            tick_cnt <= '0;
            state    <= PLAY;
          end
          PLAY: begin
            if (tick_wrap) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt - 6'd1;
`ifdef SONG_SEQ_GAP_EN
              if (note_end) begin
                gap_cnt <= '0;
                state   <= GAP;
              end
`endif
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef SONG_SEQ_GAP_EN
          GAP: gap_cnt <= gap_cnt + GW'(1);
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Autoplay controller for the piano buzzer path. Steps through a melody ROM of (note index, duration) entries, drives the 8-bit note index into the buzzer's tone generator for the programmed number of tempo ticks, and arbitrates against the live keyboard so a pressed key always overrides playback. Sits between the key decoder / melody ROM and the buzzer.

## Interface
- TICK_DIV, 100_000: clk cycles per duration unit (tempo tick); must be >= 2
- SONG_LEN, 32: ROM depth in entries; address width is clog2(SONG_LEN)
- GAP_CYCLES, 5_000: silence cycles inserted between notes (only with gap feature); must be >= 1

- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- play  in  1  single-cycle start pulse; honoured only in IDLE
- stop  in  1  single-cycle abort pulse; honoured in every state
- loop_en  in  1  level; restart from entry 0 at end of song
- key_note  in  8  live key index, 0 = no key
- rom_addr  out  clog2(SONG_LEN)  melody ROM address
- rom_data  in  14  [13:6] note index (0 = rest, 1..59 tone), [5:0] duration in ticks (0 = end marker); valid 1 cycle after rom_addr
- note_out  out  8  registered note index to buzzer; 0 = silent
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on natural end of a non-looping song

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE: ptr = 0, rom_addr = 0. play -> FETCH.
- FETCH (1 cycle): rom_addr = ptr; -> LOAD.
- LOAD (1 cycle): sample rom_data. Duration 0 -> end of song: loop_en high -> ptr = 0, FETCH; else done = 1, IDLE. Otherwise cur_note = note field, dur_cnt = duration, tick_cnt = 0 -> PLAY.
- PLAY: tick_cnt counts 0..TICK_DIV-1 and wraps; each wrap decrements dur_cnt. On the wrap where dur_cnt == 1 -> GAP (feature on) or advance (feature off).
- GAP: silence for GAP_CYCLES cycles, then advance.
- Advance: ptr == SONG_LEN-1 -> same handling as end marker (loop or done/IDLE); else ptr + 1 -> FETCH.
- Sequencer note = cur_note in PLAY, 0 in all other states. Rest entries (note 0) time normally but are silent.
- Arbitration: key_note != 0 -> note_out = key_note, else sequencer note. Sequencer timing keeps running under a key press (no pause).
- stop: next state IDLE, ptr = 0, no done pulse. stop and play in the same cycle: stop wins, block stays/returns IDLE.
- play while busy: ignored.
- loop_en sampled only at the end-of-song decision.

## Timing
- Reset values: note_out = 0, busy = 0, done = 0, rom_addr = 0, state IDLE, all counters 0.
- play at cycle N -> FETCH at N+1, LOAD at N+2, PLAY at N+3; note_out shows first note at N+4 (registered).
- Note length in PLAY = duration x TICK_DIV cycles exactly.
- Inter-note overhead: FETCH + LOAD = 2 silent cycles, plus GAP_CYCLES when gap feature on.
- key_note -> note_out latency 1 cycle, in every state including IDLE and reset release.
- done asserted in the cycle after LOAD/advance decides end; busy drops the same cycle.
- Reset mid-song: everything returns to reset values next edge; no done pulse.

## Configuration
- SONG_SEQ_GAP_EN defined: GAP state present, GAP_CYCLES of silence after every note (repeated same notes are audibly separated).
- Undefined: GAP state removed, PLAY advances directly to FETCH; GAP_CYCLES unused.

## Test plan
- TICK_DIV=4, ROM {(12,2),(24,1),(x,0)}, play -> note_out 12 for 8 cycles, 24 for 4 cycles, then done pulse once, busy low, note_out 0.
- Same ROM, loop_en=1 -> sequence 12,24,12,24... with no done pulse; stop mid-note -> note_out 0 and busy 0 one cycle later, no done.
- SONG_SEQ_GAP_EN, GAP_CYCLES=2, ROM {(7,1),(7,1),(x,0)} -> 7 for 4 cycles, 0 for 4 cycles (gap + FETCH/LOAD), 7 for 4 cycles.
- key_note=33 held during playback of note 12 -> note_out 33 one cycle later; release -> note_out returns to current sequencer note; song timing unchanged.
- SONG_LEN=4, ROM with no end marker -> plays entries 0..3 then done (or wraps to 0 with loop_en).
- play and stop same cycle in IDLE -> stays IDLE, busy 0; play while busy -> no restart, ptr unchanged.
